ready_valid_transmitter: RTL and testbench

READY_VALID_TRANSMITTER -- requirements
Module: ready_valid_transmitter

---
 rtl/ready_valid_transmitter.sv | 181 ++++++++++++++++++
 tb/tb_ready_valid_transmitter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ready_valid_transmitter.sv
// Two-entry ready/valid transmit buffer with burst beat tracking.
// A registered head word drives data_out; a second register absorbs one word of backpressure.

module ready_valid_transmitter #(
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [DATA_W-1:0]            load_data,
    output logic                         valid,
    input  logic                         ready,
    output logic [DATA_W-1:0]            data_out,
    output logic                         last,
    output logic                         en_data_Tx,
    output logic [$clog2(BURST_LEN)-1:0] beat_cnt,
    output logic                         busy
);

    localparam int CNT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_r;
    logic               load_ready_r;
    logic               valid_r;
    logic               busy_r;
    logic [CNT_W-1:0]   beat_r;
    logic [DATA_W-1:0]  head_r;
    logic [DATA_W-1:0]  tail_r;
    logic               push_s;
    logic               pop_s;

    function automatic logic [CNT_W-1:0] next_beat(input logic [CNT_W-1:0] cur);
        if (cur == LAST_BEAT) begin
            return {CNT_W{1'b0}};
        end else begin
            return cur + CNT_W'(1);
        end
    endfunction

    // Handshake qualifiers; load_ready_r is low in FULL, so offers there are ignored.
    always_comb begin
        push_s = load_valid && load_ready_r;
        pop_s  = valid_r && ready;
    end

    // Occupancy FSM with registered handshake/status outputs and the beat counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= EMPTY;
            load_ready_r <= 1'b1;
            valid_r      <= 1'b0;
            busy_r       <= 1'b0;
            beat_r       <= {CNT_W{1'b0}};
        end else begin
            if (pop_s) begin
                beat_r <= next_beat(beat_r);
            end
            case (state_r)
                EMPTY: begin
                    if (push_s) begin
                        state_r      <= ONE;
                        valid_r      <= 1'b1;
                        busy_r       <= 1'b1;
                        load_ready_r <= 1'b1;
                    end
                end
                ONE: begin
                    if (push_s && !pop_s) begin
                        state_r      <= FULL;
                        load_ready_r <= 1'b0;
                    end else if (pop_s && !push_s) begin
                        state_r <= EMPTY;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                FULL: begin
                    if (pop_s) begin
                        state_r      <= ONE;
                        load_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= EMPTY;
                    load_ready_r <= 1'b1;
                    valid_r      <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    // Word storage: no reset needed, contents only matter while valid_r says so.
    always_ff @(posedge clk) begin
        case (state_r)
            EMPTY: begin
                if (push_s) begin
                    head_r <= load_data;
                end
            end
            ONE: begin
                if (push_s && pop_s) begin
                    head_r <= load_data;
                end else if (push_s) begin
                    tail_r <= load_data;
                end
            end
            FULL: begin
                if (pop_s) begin
                    head_r <= tail_r;
                end
            end
            default: begin
                head_r <= head_r;
            end
        endcase
    end

    assign load_ready = load_ready_r;
    assign valid      = valid_r;
    assign busy       = busy_r;
    assign data_out   = head_r;
    assign beat_cnt   = beat_r;
    assign en_data_Tx = pop_s;
    assign last       = valid_r && (beat_r == LAST_BEAT);

endmodule

// Protocol checker for the transmitter ports; instantiate alongside the block.
module ready_valid_transmitter_checker #(
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 4
) (
    input logic                         clk,
    input logic                         reset,
    input logic                         load_ready,
    input logic                         valid,
    input logic                         ready,
    input logic [DATA_W-1:0]            data_out,
    input logic                         last,
    input logic                         en_data_Tx,
    input logic [$clog2(BURST_LEN)-1:0] beat_cnt,
    input logic                         busy
);

    logic              started_r;
    logic              prev_reset_r;
    logic              prev_valid_r;
    logic              prev_ready_r;
    logic [DATA_W-1:0] prev_data_r;

    // Compare the present port values with the history captured at the previous edge.
    always_ff @(posedge clk) begin
        started_r    <= 1'b1;
        prev_reset_r <= reset;
        prev_valid_r <= valid;
        prev_ready_r <= ready;
        prev_data_r  <= data_out;
        if (started_r) begin
            assert (en_data_Tx == (valid && ready));
            assert (valid == busy);
            assert (!last || valid);
            if (!prev_reset_r) begin
                assert (!valid && !busy && load_ready && (beat_cnt == '0));
            end
            if (prev_reset_r && prev_valid_r && !prev_ready_r) begin
                assert (valid && (data_out == prev_data_r));
            end
        end
    end

endmodule

// File: tb/tb_ready_valid_transmitter.sv
// Directed scoreboard bench for ready_valid_transmitter (DATA_W=64, BURST_LEN=4).
module tb_ready_valid_transmitter;

    localparam int DATA_W = 64;
    localparam int BL     = 4;
    localparam int CNT_W  = $clog2(BL);

    logic              clk = 1'b0;
    logic              reset;
    logic              load_valid;
    logic              load_ready;
    logic [DATA_W-1:0] load_data;
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data_out;
    logic              last;
    logic              en_data_Tx;
    logic [CNT_W-1:0]  beat_cnt;
    logic              busy;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  beat;
        logic              is_last;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   push_idx   = 0;

    always #5 clk = ~clk;

    ready_valid_transmitter #(.DATA_W(DATA_W), .BURST_LEN(BL)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .valid(valid), .ready(ready), .data_out(data_out),
        .last(last), .en_data_Tx(en_data_Tx), .beat_cnt(beat_cnt), .busy(busy)
    );

    ready_valid_transmitter_checker #(.DATA_W(DATA_W), .BURST_LEN(BL)) chk (
        .clk(clk), .reset(reset), .load_ready(load_ready), .valid(valid), .ready(ready),
        .data_out(data_out), .last(last), .en_data_Tx(en_data_Tx), .beat_cnt(beat_cnt),
        .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Queue the word the receiver must see; beat position follows push order since reset.
    task automatic expect_word(input logic [DATA_W-1:0] d);
        exp_t e;
        e.data    = d;
        e.beat    = CNT_W'(push_idx % BL);
        e.is_last = ((push_idx % BL) == BL - 1);
        exp_q.push_back(e);
        push_idx++;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every downstream transfer pops one expected word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid === 1'b1 && ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_transfer: got data %h, required no transfer", data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_data", data_out, e.data);
                    check("xfer_beat", 64'(beat_cnt), 64'(e.beat));
                    check("xfer_last", 64'(last), 64'(e.is_last));
                    check("xfer_en", 64'(en_data_Tx), 64'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        load_valid = 1'b0;
        ready      = 1'b0;
        load_data  = 64'd0;
        cycle();
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_last", 64'(last), 64'd0);
        check("rst_en", 64'(en_data_Tx), 64'd0);
        check("rst_load_ready", 64'(load_ready), 64'd1);
        check("rst_beat", 64'(beat_cnt), 64'd0);
        cycle();
        reset = 1'b1;
        cycle();

        // Single word with ready held high.
        ready      = 1'b1;
        load_valid = 1'b1;
        load_data  = 64'hA5A5_0000_0000_0001;
        expect_word(load_data);
        cycle();
        load_valid = 1'b0;
        check("single_valid", 64'(valid), 64'd1);
        check("single_data", data_out, 64'hA5A5_0000_0000_0001);
        cycle();
        check("single_empty_valid", 64'(valid), 64'd0);
        check("single_empty_busy", 64'(busy), 64'd0);
        check("single_load_ready", 64'(load_ready), 64'd1);

        // Backpressure: fill both entries, offer a third that must be refused.
        ready      = 1'b0;
        load_valid = 1'b1;
        load_data  = 64'h11;
        expect_word(load_data);
        cycle();
        check("bp_ready_one", 64'(load_ready), 64'd1);
        load_data = 64'h22;
        expect_word(load_data);
        cycle();
        check("bp_ready_full", 64'(load_ready), 64'd0);
        check("bp_head", data_out, 64'h11);
        load_data = 64'h33;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("bp_hold_ready", 64'(load_ready), 64'd0);
            check("bp_hold_valid", 64'(valid), 64'd1);
            check("bp_hold_data", data_out, 64'h11);
        end
        ready = 1'b1;
        cycle();
        load_valid = 1'b0;
        check("bp_second_head", data_out, 64'h22);
        check("bp_second_valid", 64'(valid), 64'd1);
        cycle();
        check("bp_drained", 64'(valid), 64'd0);

        // Completes the first burst: beat 3 with last.
        load_valid = 1'b1;
        load_data  = 64'h44;
        expect_word(load_data);
        cycle();
        load_valid = 1'b0;
        cycle();
        check("burst_wrap_beat", 64'(beat_cnt), 64'd0);

        // Streaming eight words, one transfer per cycle.
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            load_valid = 1'b1;
            load_data  = 64'(i);
            expect_word(load_data);
            cycle();
            check("stream_valid", 64'(valid), 64'd1);
            check("stream_head", data_out, 64'(i));
            check("stream_en", 64'(en_data_Tx), 64'd1);
        end
        load_valid = 1'b0;
        cycle();
        check("stream_end_valid", 64'(valid), 64'd0);

        // Simultaneous push and pop while holding one word.
        ready      = 1'b0;
        load_valid = 1'b1;
        load_data  = 64'h10;
        expect_word(load_data);
        cycle();
        ready     = 1'b1;
        load_data = 64'h20;
        expect_word(load_data);
        cycle();
        load_valid = 1'b0;
        check("pp_head", data_out, 64'h20);
        check("pp_valid", 64'(valid), 64'd1);
        check("pp_load_ready", 64'(load_ready), 64'd1);
        cycle();
        check("pp_empty", 64'(valid), 64'd0);
        check("pp_beat", 64'(beat_cnt), 64'd2);

        // Reset mid-burst with both entries full; those words are discarded.
        ready      = 1'b0;
        load_valid = 1'b1;
        load_data  = 64'h55;
        cycle();
        load_data = 64'h66;
        cycle();
        check("mid_full", 64'(load_ready), 64'd0);
        load_valid = 1'b0;
        reset      = 1'b0;
        cycle();
        check("mid_rst_valid", 64'(valid), 64'd0);
        check("mid_rst_beat", 64'(beat_cnt), 64'd0);
        check("mid_rst_load_ready", 64'(load_ready), 64'd1);
        reset    = 1'b1;
        push_idx = 0;
        exp_q.delete();
        ready = 1'b1;
        cycle();
        check("empty_ready_en", 64'(en_data_Tx), 64'd0);
        check("empty_ready_valid", 64'(valid), 64'd0);
        check("empty_ready_beat", 64'(beat_cnt), 64'd0);
        load_valid = 1'b1;
        load_data  = 64'h77;
        expect_word(load_data);
        cycle();
        load_valid = 1'b0;
        check("post_rst_head", data_out, 64'h77);
        cycle();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            cycle();
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
